mcb_dat_seq: RTL and testbench

- Data-phase sequencer for the sdrc_lite SDR SDRAM back-end; sits directly upstream of MCB_DAT_FF.
- Converts one-cycle read/write "go" pulses from the command stage into the d_wr_ld, d_dp_oe and d_dp_ie strobes that MCB_DAT_FF consumes.
- Produces MCB-side read-valid and write-accept pulses.
- Honours CAS latency, burst length and input-register delay, and reports illegal overlapping commands.

---
 rtl/mcb_dat_seq_pkg.sv | 49 ++++
 rtl/mcb_dat_seq_cnt.sv | 46 ++++
 rtl/mcb_dat_seq.sv | 159 +++++++++++++++
 tb/tb_mcb_dat_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mcb_dat_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mcb_dat_seq_pkg
//  Purpose  : Shared definitions for the sdrc_lite data-phase sequencer.
//             Provides the sequencer state encoding, the burst-code decode
//             constants, the default counter width and a burst-length helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mcb_dat_seq_pkg;

  // Default width of the beat and latency counters.
  localparam int C_CNT_W = 3;

  // Sequencer state encoding.
  localparam logic [1:0] C_ST_IDLE   = 2'd0;
  localparam logic [1:0] C_ST_WR     = 2'd1;
  localparam logic [1:0] C_ST_RD_LAT = 2'd2;
  localparam logic [1:0] C_ST_RD     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = C_ST_IDLE,
    S_WR     = C_ST_WR,
    S_RD_LAT = C_ST_RD_LAT,
    S_RD     = C_ST_RD
  } seq_state_t;

  // Burst-length codes as presented on cfg_bl.
  localparam logic [1:0] C_BL_1 = 2'd0;
  localparam logic [1:0] C_BL_2 = 2'd1;
  localparam logic [1:0] C_BL_4 = 2'd2;
  localparam logic [1:0] C_BL_8 = 2'd3;

  // Burst code -> (beats - 1), the value the beat counter starts from.
  function automatic logic [2:0] bl_minus1(input logic [1:0] code);
    logic [2:0] w_val;
    w_val = 3'd0;
    case (code)
      C_BL_1:  w_val = 3'd0;
      C_BL_2:  w_val = 3'd1;
      C_BL_4:  w_val = 3'd3;
      C_BL_8:  w_val = 3'd7;
      default: w_val = 3'd0;
    endcase
    return w_val;
  endfunction

endpackage : mcb_dat_seq_pkg
`default_nettype wire

// File: rtl/mcb_dat_seq_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : mcb_dat_seq_cnt
//  Purpose  : Loadable down-counter with a zero flag. Decrements saturate at
//             zero; a load takes priority over a decrement.
//  Ports    : clk       - clock
//             rst_n     - asynchronous active-low reset
//             i_sclr_n  - synchronous clear, active low
//             i_ld      - load i_ld_val
//             i_ld_val  - load value
//             i_dec     - decrement (no wrap below zero)
//             o_zero    - count is zero
//  Revision : 1.0  initial release
// ============================================================================
module mcb_dat_seq_cnt
  import mcb_dat_seq_pkg::*;
#(
  parameter int CNT_W = C_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sclr_n,
  input  logic             i_ld,
  input  logic [CNT_W-1:0] i_ld_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_sclr_n) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_ld_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule : mcb_dat_seq_cnt
`default_nettype wire

// File: rtl/mcb_dat_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mcb_dat_seq
//  Purpose  : Data-phase sequencer for the sdrc_lite SDR SDRAM back-end.
//             Turns one-cycle write/read go pulses into the write-load,
//             DQ output-enable and DQ input-capture strobes for MCB_DAT_FF,
//             plus MCB-side read-valid / write-accept pulses. Honours CAS
//             latency, burst length and the input-register delay, and flags
//             go pulses that cannot be accepted.
//  Ports    : mcb_clk, mcb_rst_n (async, active low), mcb_sclr_n (sync clear)
//             c_wr_go, c_rd_go  - go pulses from the command stage
//             cfg_cl, cfg_bl    - CAS latency / burst code, captured on go
//             c_bst             - burst terminate (only with the macro below)
//             d_wr_ld, d_dp_oe, d_dp_ie - MCB_DAT_FF strobes
//             mcb_rvld, mcb_wack        - MCB read-valid / write-accept
//             d_rdy, d_cmd_err          - idle flag / go-rejected pulse
//  Options  : MCB_DAT_SEQ_BST_EN adds the c_bst burst-terminate input.
//  Revision : 1.0  initial release
// ============================================================================
module mcb_dat_seq
  import mcb_dat_seq_pkg::*;
#(
  parameter int CNT_W  = C_CNT_W,
  parameter int RD_DLY = 1
) (
  input  logic       mcb_clk,
  input  logic       mcb_rst_n,
  input  logic       mcb_sclr_n,
  input  logic       c_wr_go,
  input  logic       c_rd_go,
  input  logic [1:0] cfg_cl,
  input  logic [1:0] cfg_bl,
`ifdef MCB_DAT_SEQ_BST_EN
  input  logic       c_bst,
`endif
  output logic       d_wr_ld,
  output logic       d_dp_oe,
  output logic       d_dp_ie,
  output logic       mcb_rvld,
  output logic       mcb_wack,
  output logic       d_rdy,
  output logic       d_cmd_err
);

  seq_state_t       r_state;
  logic             r_rvld;
  logic             r_err;

  logic             w_bst;
  logic             w_rdy;
  logic             w_acc_wr;
  logic             w_acc_rd;
  logic             w_both;
  logic             w_busy_go;
  logic [1:0]       w_cl_eff;
  logic [CNT_W-1:0] w_lat;
  logic [CNT_W-1:0] w_lat_ld;
  logic [CNT_W-1:0] w_beat_ld;
  logic             w_lat_short;
  logic             w_lat_zero;
  logic             w_beat_zero;

`ifdef MCB_DAT_SEQ_BST_EN
  assign w_bst = c_bst;
`else
  assign w_bst = 1'b0;
`endif

  // Idle also waits out the trailing mcb_rvld beat after a read.
  assign w_rdy     = (r_state == S_IDLE) && !r_rvld;
  assign w_acc_wr  = w_rdy && mcb_sclr_n && c_wr_go;
  assign w_acc_rd  = w_rdy && mcb_sclr_n && c_rd_go && !c_wr_go;
  assign w_both    = w_rdy && mcb_sclr_n && c_wr_go && c_rd_go;
  assign w_busy_go = !w_rdy && (c_wr_go || c_rd_go);

  // Total read latency L = CL + RD_DLY, with CL code 0 behaving as 1.
  assign w_cl_eff    = (cfg_cl == 2'd0) ? 2'd1 : cfg_cl;
  assign w_lat       = CNT_W'(w_cl_eff) + CNT_W'(RD_DLY);
  assign w_lat_short = (w_lat == CNT_W'(1));
  // RD_LAT lasts L-1 cycles; the counter expires in its final cycle.
  assign w_lat_ld    = w_lat - CNT_W'(2);
  assign w_beat_ld   = CNT_W'(bl_minus1(cfg_bl));

  mcb_dat_seq_cnt #(.CNT_W(CNT_W)) u_lat_cnt (
    .clk      (mcb_clk),
    .rst_n    (mcb_rst_n),
    .i_sclr_n (mcb_sclr_n),
    .i_ld     (w_acc_rd && !w_lat_short),
    .i_ld_val (w_lat_ld),
    .i_dec    (r_state == S_RD_LAT),
    .o_zero   (w_lat_zero)
  );

  // Beat count is captured at go time and held through RD_LAT.
  mcb_dat_seq_cnt #(.CNT_W(CNT_W)) u_beat_cnt (
    .clk      (mcb_clk),
    .rst_n    (mcb_rst_n),
    .i_sclr_n (mcb_sclr_n),
    .i_ld     (w_acc_wr || w_acc_rd),
    .i_ld_val (w_beat_ld),
    .i_dec    ((r_state == S_WR) || (r_state == S_RD)),
    .o_zero   (w_beat_zero)
  );

  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      r_state <= S_IDLE;
      r_rvld  <= 1'b0;
      r_err   <= 1'b0;
    end else if (!mcb_sclr_n) begin
      r_state <= S_IDLE;
      r_rvld  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // mcb_rvld trails d_dp_ie by the MCB_DAT_FF output register.
      r_rvld <= (r_state == S_RD);
      r_err  <= w_busy_go;
      case (r_state)
        S_IDLE: begin
          if (w_acc_wr) begin
            r_state <= S_WR;
          end else if (w_acc_rd) begin
            r_state <= w_lat_short ? S_RD : S_RD_LAT;
          end
        end
        S_WR: begin
          if (w_bst || w_beat_zero) begin
            r_state <= S_IDLE;
          end
        end
        S_RD_LAT: begin
          if (w_bst) begin
            r_state <= S_IDLE;
          end else if (w_lat_zero) begin
            r_state <= S_RD;
          end
        end
        S_RD: begin
          if (w_bst || w_beat_zero) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The first write beat is loaded in the go cycle itself.
  assign d_wr_ld   = w_acc_wr || ((r_state == S_WR) && !w_beat_zero && !w_bst);
  assign mcb_wack  = d_wr_ld;
  assign d_dp_oe   = (r_state == S_WR);
  assign d_dp_ie   = (r_state == S_RD);
  assign mcb_rvld  = r_rvld;
  assign d_rdy     = w_rdy;
  // Simultaneous go in idle flags the read at once; busy gos flag a cycle later.
  assign d_cmd_err = r_err || w_both;

endmodule : mcb_dat_seq
`default_nettype wire

// File: tb/tb_mcb_dat_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mcb_dat_seq
//  Purpose  : Scoreboard bench for mcb_dat_seq. Stimulus pushes the expected
//             cycle numbers of every strobe pulse into per-output queues; a
//             negedge monitor pops and compares whenever an output is high.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mcb_dat_seq;

  localparam int RD_DLY = 1;
  localparam int NS     = 6;

  logic       mcb_clk = 1'b0;
  logic       mcb_rst_n;
  logic       mcb_sclr_n;
  logic       c_wr_go;
  logic       c_rd_go;
  logic [1:0] cfg_cl;
  logic [1:0] cfg_bl;
`ifdef MCB_DAT_SEQ_BST_EN
  logic       c_bst;
`endif
  logic       d_wr_ld;
  logic       d_dp_oe;
  logic       d_dp_ie;
  logic       mcb_rvld;
  logic       mcb_wack;
  logic       d_rdy;
  logic       d_cmd_err;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    rdy_cyc  = 0;
  bit    exp_rdy_now = 1'b1;
  bit    mon_en   = 1'b0;
  bit    mon_act [NS];
  int    exp_q   [NS][$];
  string s_name  [NS] = '{"d_wr_ld", "mcb_wack", "d_dp_oe", "d_dp_ie", "mcb_rvld", "d_cmd_err"};

  mcb_dat_seq #(.RD_DLY(RD_DLY)) dut (
    .mcb_clk    (mcb_clk),
    .mcb_rst_n  (mcb_rst_n),
    .mcb_sclr_n (mcb_sclr_n),
    .c_wr_go    (c_wr_go),
    .c_rd_go    (c_rd_go),
    .cfg_cl     (cfg_cl),
    .cfg_bl     (cfg_bl),
`ifdef MCB_DAT_SEQ_BST_EN
    .c_bst      (c_bst),
`endif
    .d_wr_ld    (d_wr_ld),
    .d_dp_oe    (d_dp_oe),
    .d_dp_ie    (d_dp_ie),
    .mcb_rvld   (mcb_rvld),
    .mcb_wack   (mcb_wack),
    .d_rdy      (d_rdy),
    .d_cmd_err  (d_cmd_err)
  );

  always #5 mcb_clk = ~mcb_clk;

  always @(posedge mcb_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, got, exp);
    end
  endtask

  function automatic void push(input int s, input int c);
    if (exp_q[s].size() == 0 || exp_q[s][$] != c) exp_q[s].push_back(c);
  endfunction

  function automatic void flush_after(input int c);
    for (int s = 0; s < NS; s++)
      while (exp_q[s].size() != 0 && exp_q[s][$] > c) void'(exp_q[s].pop_back());
  endfunction

  // Monitor: a high output must match the next queued cycle; a queued cycle
  // that passes with the output low is a missing pulse.
  always @(negedge mcb_clk) begin
    if (mon_en) begin
      mon_act[0] = d_wr_ld;
      mon_act[1] = mcb_wack;
      mon_act[2] = d_dp_oe;
      mon_act[3] = d_dp_ie;
      mon_act[4] = mcb_rvld;
      mon_act[5] = d_cmd_err;
      for (int s = 0; s < NS; s++) begin
        if (mon_act[s]) begin
          if (exp_q[s].size() == 0) chk({s_name[s], " unexpected pulse"}, cyc, -1);
          else                      chk(s_name[s], cyc, exp_q[s].pop_front());
        end else if (exp_q[s].size() != 0 && exp_q[s][0] <= cyc) begin
          chk({s_name[s], " missing pulse"}, -1, exp_q[s].pop_front());
        end
      end
      chk("d_rdy", int'(d_rdy), int'(exp_rdy_now));
    end
  end

  // One stimulus cycle plus the reference model for it: bursts occupy the
  // sequencer from go until rdy_cyc, and every strobe is a run of cycles.
  task automatic drive(input bit wr, input bit rd, input logic [1:0] cl,
                       input logic [1:0] bl, input bit sclr);
    int nb;
    int lat;
    @(posedge mcb_clk);
    #1;
    c_wr_go    = wr;
    c_rd_go    = rd;
    cfg_cl     = cl;
    cfg_bl     = bl;
    mcb_sclr_n = !sclr;
    exp_rdy_now = (cyc >= rdy_cyc);
    nb  = 1 << bl;
    lat = ((cl == 2'd0) ? 1 : int'(cl)) + RD_DLY;
    if (sclr) begin
      flush_after(cyc);
      rdy_cyc = cyc + 1;
    end else if (exp_rdy_now) begin
      if (wr) begin
        for (int k = 0; k < nb; k++) begin
          push(0, cyc + k);
          push(1, cyc + k);
        end
        for (int k = 1; k <= nb; k++) push(2, cyc + k);
        rdy_cyc = cyc + nb + 1;
        if (rd) push(5, cyc);
      end else if (rd) begin
        for (int k = 0; k < nb; k++) begin
          push(3, cyc + lat + k);
          push(4, cyc + lat + k + 1);
        end
        rdy_cyc = cyc + lat + nb + 1;
      end
    end else if (wr || rd) begin
      push(5, cyc + 1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges: outputs must clear
  // before the next edge.
  task automatic async_reset_mid();
    @(posedge mcb_clk);
    #3;
    mcb_rst_n = 1'b0;
    #1;
    for (int s = 0; s < NS; s++) exp_q[s].delete();
    exp_rdy_now = 1'b1;
    rdy_cyc     = 0;
    chk("async rst d_wr_ld",   int'(d_wr_ld),   0);
    chk("async rst d_dp_oe",   int'(d_dp_oe),   0);
    chk("async rst d_dp_ie",   int'(d_dp_ie),   0);
    chk("async rst mcb_rvld",  int'(mcb_rvld),  0);
    chk("async rst d_cmd_err", int'(d_cmd_err), 0);
    chk("async rst d_rdy",     int'(d_rdy),     1);
    repeat (2) @(posedge mcb_clk);
    #2;
    mcb_rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    mcb_rst_n  = 1'b0;
    mcb_sclr_n = 1'b1;
    c_wr_go    = 1'b0;
    c_rd_go    = 1'b0;
    cfg_cl     = 2'd0;
    cfg_bl     = 2'd0;
`ifdef MCB_DAT_SEQ_BST_EN
    c_bst      = 1'b0;
`endif
    repeat (3) @(posedge mcb_clk);
    #2;
    chk("reset d_wr_ld",   int'(d_wr_ld),   0);
    chk("reset mcb_wack",  int'(mcb_wack),  0);
    chk("reset d_dp_oe",   int'(d_dp_oe),   0);
    chk("reset d_dp_ie",   int'(d_dp_ie),   0);
    chk("reset mcb_rvld",  int'(mcb_rvld),  0);
    chk("reset d_cmd_err", int'(d_cmd_err), 0);
    chk("reset d_rdy",     int'(d_rdy),     1);
    mcb_rst_n = 1'b1;
    mon_en    = 1'b1;
    idle(4);

    // Write, BL=4.
    drive(1'b1, 1'b0, 2'd0, 2'd2, 1'b0);
    idle(8);
    // Read, CL=2, BL=2.
    drive(1'b0, 1'b1, 2'd2, 2'd1, 1'b0);
    idle(8);
    // Both gos together in idle, BL=1: write wins, read flagged.
    drive(1'b1, 1'b1, 2'd1, 2'd0, 1'b0);
    idle(4);
    // Write go arriving two cycles into a read.
    drive(1'b0, 1'b1, 2'd2, 2'd2, 1'b0);
    idle(1);
    drive(1'b1, 1'b0, 2'd2, 2'd2, 1'b0);
    idle(12);
    // Synchronous clear on the second beat of a BL=8 write.
    drive(1'b1, 1'b0, 2'd0, 2'd3, 1'b0);
    drive(1'b0, 1'b0, 2'd0, 2'd3, 1'b1);
    idle(4);
    // CL code 0 behaves as CL=1.
    drive(1'b0, 1'b1, 2'd0, 2'd2, 1'b0);
    idle(8);
    // Asynchronous reset mid-read, then a BL=1 read with CL=3.
    drive(1'b0, 1'b1, 2'd3, 2'd3, 1'b0);
    idle(3);
    async_reset_mid();
    idle(2);
    drive(1'b0, 1'b1, 2'd3, 2'd0, 1'b0);
    idle(8);

    // Randomized traffic, including gos while busy and occasional clears.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       drive(1'b0, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1);
      else if (r < 17) drive(1'b1, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
      else if (r < 32) drive(1'b0, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
      else if (r < 35) drive(1'b1, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
      else             drive(1'b0, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
    end
    idle(20);
    @(negedge mcb_clk);
    #1;
    mon_en = 1'b0;
    for (int s = 0; s < NS; s++) chk({s_name[s], " pulses left pending"}, exp_q[s].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mcb_dat_seq
`default_nettype wire
